// File: rtl/sram_responder_pkg.sv
// Shared constants and lane helper for the external SRAM bus responder.
// Widths mirror the controller-side SRAM_ADDR_LEN / SRAM_DATA_LEN / SRAM_READ_LATENCY settings.
package sram_responder_pkg;
  localparam int SRAM_ADDR_LEN     = 17;
  localparam int SRAM_DATA_LEN     = 32;
  localparam int SRAM_READ_LATENCY = 2;

  // Bit mask of the 16-bit lanes selected by the active-low byte-lane enables.
  function automatic logic [SRAM_DATA_LEN-1:0] lane_mask(input logic ub_n, input logic lb_n);
    return {{16{~ub_n}}, {16{~lb_n}}};
  endfunction
endpackage

// File: rtl/sram_responder_if.sv
// SRAM control/address bundle as seen from the controller (master) and the device (slave).
// The bidirectional DQ bus stays a plain inout port on the device.
interface sram_responder_if
  import sram_responder_pkg::*;
#(
  parameter int ADDR_W = SRAM_ADDR_LEN
);
  logic [ADDR_W-1:0] SRAM_ADDR;
  logic              SRAM_UB_N;
  logic              SRAM_LB_N;
  logic              SRAM_WE_N;
  logic              SRAM_CE_N;
  logic              SRAM_OE_N;

  modport master (
    output SRAM_ADDR, SRAM_UB_N, SRAM_LB_N, SRAM_WE_N, SRAM_CE_N, SRAM_OE_N
  );

  modport slave (
    input SRAM_ADDR, SRAM_UB_N, SRAM_LB_N, SRAM_WE_N, SRAM_CE_N, SRAM_OE_N
  );
endinterface

// File: rtl/sram_read_pipe.sv
// Fixed-depth delay line for read responses: {valid, ub_n, lb_n, data}.
// Valids clear synchronously on rst; payload flops carry no reset.
module sram_read_pipe #(
  parameter int LAT = 2,
  parameter int W   = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_vld,
  input  logic         in_ub_n,
  input  logic         in_lb_n,
  input  logic [W-1:0] in_dat,
  output logic         out_vld,
  output logic         out_ub_n,
  output logic         out_lb_n,
  output logic [W-1:0] out_dat,
  output logic         any_vld
);
  logic [LAT-1:0]        vld_q, vld_d;
  logic [LAT-1:0]        ub_n_q, ub_n_d;
  logic [LAT-1:0]        lb_n_q, lb_n_d;
  logic [LAT-1:0][W-1:0] dat_q, dat_d;

  always_comb begin
    vld_d     = vld_q;
    ub_n_d    = ub_n_q;
    lb_n_d    = lb_n_q;
    dat_d     = dat_q;
    vld_d[0]  = in_vld;
    ub_n_d[0] = in_ub_n;
    lb_n_d[0] = in_lb_n;
    dat_d[0]  = in_dat;
    for (int i = 1; i < LAT; i++) begin
      vld_d[i]  = vld_q[i-1];
      ub_n_d[i] = ub_n_q[i-1];
      lb_n_d[i] = lb_n_q[i-1];
      dat_d[i]  = dat_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
    end else begin
      vld_q <= vld_d;
    end
    ub_n_q <= ub_n_d;
    lb_n_q <= lb_n_d;
    dat_q  <= dat_d;
  end

  assign out_vld  = vld_q[LAT-1];
  assign out_ub_n = ub_n_q[LAT-1];
  assign out_lb_n = lb_n_q[LAT-1];
  assign out_dat  = dat_q[LAT-1];
  assign any_vld  = |vld_q;
endmodule

// File: rtl/sram_responder.sv
// Behavioural-accurate external SRAM device: lane-masked word storage, pipelined reads on DQ,
// access counters and sticky contention / out-of-range flags for end-to-end checking.
module sram_responder
  import sram_responder_pkg::*;
#(
  parameter int ADDR_W       = SRAM_ADDR_LEN,
  parameter int DEPTH        = 65536,
  parameter int READ_LATENCY = SRAM_READ_LATENCY,
  parameter int CNT_W        = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  sram_responder_if.slave          bus,
  inout  wire  [SRAM_DATA_LEN-1:0] SRAM_DQ,
  output logic [CNT_W-1:0]         rd_count,
  output logic [CNT_W-1:0]         wr_count,
  output logic                     busy,
  output logic                     contention,
  output logic                     oob_err
);
  localparam int              IDX_W   = $clog2(DEPTH);
  localparam logic [ADDR_W:0] DEPTH_A = (ADDR_W + 1)'(DEPTH);

  logic [SRAM_DATA_LEN-1:0] mem [DEPTH];

  logic                     req_wr, req_rd, in_range;
  logic [IDX_W-1:0]         idx;
  logic [SRAM_DATA_LEN-1:0] rd_dat, wmask;
  logic                     out_vld, out_ub_n, out_lb_n, drive;
  logic [SRAM_DATA_LEN-1:0] out_dat;

  logic [CNT_W-1:0] rd_count_q, rd_count_d, wr_count_q, wr_count_d;
  logic             contention_q, contention_d, oob_err_q, oob_err_d;

  assign req_wr   = ~bus.SRAM_CE_N & ~bus.SRAM_WE_N;
  assign req_rd   = ~bus.SRAM_CE_N & bus.SRAM_WE_N & ~bus.SRAM_OE_N;
  assign in_range = {1'b0, bus.SRAM_ADDR} < DEPTH_A;
  assign idx      = bus.SRAM_ADDR[IDX_W-1:0];
  assign wmask    = lane_mask(bus.SRAM_UB_N, bus.SRAM_LB_N);
  // Snapshot is the pre-write array content, so a same-edge or later write cannot disturb it.
  assign rd_dat   = in_range ? mem[idx] : '0;

  always_ff @(posedge clk) begin
    if (!rst && req_wr && in_range) begin
      mem[idx] <= (mem[idx] & ~wmask) | (SRAM_DQ & wmask);
    end
  end

  sram_read_pipe #(
    .LAT (READ_LATENCY),
    .W   (SRAM_DATA_LEN)
  ) u_read_pipe (
    .clk      (clk),
    .rst      (rst),
    .in_vld   (req_rd),
    .in_ub_n  (bus.SRAM_UB_N),
    .in_lb_n  (bus.SRAM_LB_N),
    .in_dat   (rd_dat),
    .out_vld  (out_vld),
    .out_ub_n (out_ub_n),
    .out_lb_n (out_lb_n),
    .out_dat  (out_dat),
    .any_vld  (busy)
  );

  always_comb begin
    rd_count_d   = rd_count_q + CNT_W'(req_rd);
    wr_count_d   = wr_count_q + CNT_W'(req_wr);
    contention_d = contention_q | (out_vld & req_wr);
    oob_err_d    = oob_err_q | ((req_rd | req_wr) & ~in_range);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_count_q   <= '0;
      wr_count_q   <= '0;
      contention_q <= 1'b0;
      oob_err_q    <= 1'b0;
    end else begin
      rd_count_q   <= rd_count_d;
      wr_count_q   <= wr_count_d;
      contention_q <= contention_d;
      oob_err_q    <= oob_err_d;
    end
  end

  assign rd_count   = rd_count_q;
  assign wr_count   = wr_count_q;
  assign contention = contention_q;
  assign oob_err    = oob_err_q;

  // Any controller write drops the drive in the same cycle, so DQ never has two drivers.
  assign drive         = out_vld & bus.SRAM_WE_N & ~bus.SRAM_OE_N & ~bus.SRAM_CE_N;
  assign SRAM_DQ[31:16] = (drive & ~out_ub_n) ? out_dat[31:16] : 16'bz;
  assign SRAM_DQ[15:0]  = (drive & ~out_lb_n) ? out_dat[15:0]  : 16'bz;
endmodule
